top_k_stream_feeder: RTL and testbench

Feeds the top-k block from the TCP/IP receive path. It accepts the 512-bit network stream, splits each beat into 32-bit integer lanes, and parses length-prefixed datasets. It drives the 32-bit integer stream, TLAST and the per-dataset clear flag that the top-k pipeline consumes. It sits between the network kernel rx interface and top_k_block.

---
 rtl/top_k_pkg.sv | 36 +++
 rtl/top_k_lane_buffer.sv | 85 ++++++++
 rtl/top_k_stream_feeder.sv | 105 ++++++++++
 tb/tb_top_k_stream_feeder.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/top_k_pkg.sv
// Shared constants, state encoding and keep decoding for the top-k feeder and its neighbours.
package top_k_pkg;

   localparam int INTEGER_SIZE  = 32;
   localparam int IN_WIDTH      = 512;
   localparam int LANES         = IN_WIDTH / INTEGER_SIZE;
   localparam int KEEP_WIDTH    = IN_WIDTH / 8;
   localparam int LANE_KEEP     = INTEGER_SIZE / 8;
   localparam int MSG_CNT_WIDTH = 32;

   typedef enum logic {
      HDR  = 1'b0,
      DATA = 1'b1
   } feeder_state_t;

   typedef enum logic [1:0] {
      KEEP_EMPTY = 2'd0,
      KEEP_FULL  = 2'd1,
      KEEP_BAD   = 2'd2
   } keep_kind_t;

   // A lane carries a word only when all its byte enables are set; a fully
   // cleared lane is padding; anything in between is a malformed lane.
   function automatic keep_kind_t decode_keep(input logic [LANE_KEEP-1:0] nibble);
      keep_kind_t kind;
      if (nibble == '1) begin
         kind = KEEP_FULL;
      end else if (nibble == '0) begin
         kind = KEEP_EMPTY;
      end else begin
         kind = KEEP_BAD;
      end
      return kind;
   endfunction

endpackage

// File: rtl/top_k_lane_buffer.sv
// Holds one rx beat and hands its 32-bit lanes out one at a time, lowest lane first.
module top_k_lane_buffer
   import top_k_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [IN_WIDTH-1:0]     s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   output logic [INTEGER_SIZE-1:0] lane_data,
   output logic                    lane_valid,
   output logic                    lane_err,
   input  logic                    lane_take
);

   logic [IN_WIDTH-1:0] beat_data;
   logic [LANES-1:0]    pending;
   logic [LANES-1:0]    full;
   logic [LANES-1:0]    in_pending;
   logic [LANES-1:0]    in_full;
   logic [LANES-1:0]    cur_onehot;
   logic [LANES-1:0]    rest;
   logic                advance;
   logic                load;

   // Classify every lane of the incoming beat: padding lanes never enter the pending mask.
   always_comb begin
      in_pending = '0;
      in_full    = '0;
      for (int i = 0; i < LANES; i++) begin
         case (decode_keep(s_axis_tkeep[i*LANE_KEEP +: LANE_KEEP]))
            KEEP_FULL: begin
               in_pending[i] = 1'b1;
               in_full[i]    = 1'b1;
            end
            KEEP_BAD: begin
               in_pending[i] = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // The lane pointer is the lowest still-pending lane, kept as a one-hot mask.
   assign cur_onehot = pending & (~pending + LANES'(1));
   assign rest       = pending & ~cur_onehot;

   // Select the word of the lane under the pointer.
   always_comb begin
      lane_data = '0;
      for (int i = 0; i < LANES; i++) begin
         if (cur_onehot[i]) begin
            lane_data = beat_data[i*INTEGER_SIZE +: INTEGER_SIZE];
         end
      end
   end

   assign lane_valid = |(cur_onehot & full);
   assign lane_err   = (pending != '0) && !lane_valid;

   // Malformed lanes are dropped here without waiting for the FSM.
   assign advance = lane_err || (lane_valid && lane_take);

   // Ready when empty or when the last pending lane leaves this cycle, so beats stream with no bubble.
   assign s_axis_tready = rst_n && ((pending == '0) || ((rest == '0) && advance));
   assign load          = s_axis_tvalid && s_axis_tready;

   // Capture a new beat or retire the lane just consumed.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending   <= '0;
         full      <= '0;
         beat_data <= '0;
      end else if (load) begin
         beat_data <= s_axis_tdata;
         pending   <= in_pending;
         full      <= in_full;
      end else if (advance) begin
         pending   <= rest;
      end
   end

endmodule

// File: rtl/top_k_stream_feeder.sv
// Parses length-prefixed datasets from the rx stream into the integer stream for top_k_block.
module top_k_stream_feeder
   import top_k_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [IN_WIDTH-1:0]      s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
   input  logic                     s_axis_tvalid,
   input  logic                     s_axis_tlast,
   output logic                     s_axis_tready,
   output logic [INTEGER_SIZE-1:0]  m_axis_tdata,
   output logic                     m_axis_tvalid,
   output logic                     m_axis_tlast,
   output logic                     m_axis_clear,
   input  logic                     m_axis_tready,
   output logic                     frame_err,
   output logic [MSG_CNT_WIDTH-1:0] msg_count
);

   logic [INTEGER_SIZE-1:0] lane_data;
   logic                    lane_valid;
   logic                    lane_err;
   logic                    lane_take;
   logic                    out_free;
   feeder_state_t           state;
   logic [INTEGER_SIZE-1:0] remaining;
   logic                    first_flag;

   // Segment boundaries carry no framing meaning; datasets span segments freely.
   logic unused_tlast;
   assign unused_tlast = s_axis_tlast;

   assign out_free  = !m_axis_tvalid || m_axis_tready;
   assign lane_take = lane_valid && ((state == HDR) || out_free);

   top_k_lane_buffer u_lane_buffer (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .lane_data     (lane_data),
      .lane_valid    (lane_valid),
      .lane_err      (lane_err),
      .lane_take     (lane_take)
   );

   // Header/data FSM with the registered output stage, error pulse and dataset counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= HDR;
         remaining     <= '0;
         first_flag    <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_clear  <= 1'b0;
         frame_err     <= 1'b0;
         msg_count     <= '0;
      end else begin
         frame_err <= lane_err || ((state == HDR) && lane_valid && (lane_data == '0));

         if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            msg_count <= msg_count + MSG_CNT_WIDTH'(1);
         end

         if (out_free && !((state == DATA) && lane_valid)) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_clear  <= 1'b0;
         end

         case (state)
            HDR: begin
               if (lane_valid) begin
                  remaining <= lane_data;
                  if (lane_data != '0) begin
                     state      <= DATA;
                     first_flag <= 1'b1;
                  end
               end
            end
            DATA: begin
               if (lane_valid && out_free) begin
                  m_axis_tdata  <= lane_data;
                  m_axis_tvalid <= 1'b1;
                  m_axis_clear  <= first_flag;
                  m_axis_tlast  <= (remaining == INTEGER_SIZE'(1));
                  first_flag    <= 1'b0;
                  remaining     <= remaining - INTEGER_SIZE'(1);
                  if (remaining == INTEGER_SIZE'(1)) begin
                     state <= HDR;
                  end
               end
            end
            default: begin
               state <= HDR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_top_k_stream_feeder.sv
// Self-checking bench for top_k_stream_feeder: directed datasets plus randomized streams
// compared against a word-level reference model.
module tb_top_k_stream_feeder;
   import top_k_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [511:0] s_axis_tdata;
   logic [63:0]  s_axis_tkeep;
   logic         s_axis_tvalid;
   logic         s_axis_tlast;
   logic         s_axis_tready;
   logic [31:0]  m_axis_tdata;
   logic         m_axis_tvalid;
   logic         m_axis_tlast;
   logic         m_axis_clear;
   logic         m_axis_tready;
   logic         frame_err;
   logic [31:0]  msg_count;

   int checkCount = 0;
   int passCount  = 0;
   int cyc        = 0;

   logic [511:0] beatDataQ[$];
   logic [63:0]  beatKeepQ[$];
   logic [511:0] curData = '0;
   logic [63:0]  curKeep = '0;
   logic [33:0]  expQ[$];
   logic [33:0]  obsQ[$];
   int           expErr       = 0;
   int           errSeen      = 0;
   int           expMsgsTotal = 0;
   int           readyMode    = 0;
   int           patIdx       = 0;
   logic [3:0]   readyPattern = 4'b1001;
   bit           sawTreadyLow = 0;
   int           acceptCyc    = 0;
   int           firstOutCyc  = -1;
   bit           holdPending  = 0;
   logic [34:0]  heldVal      = '0;

   top_k_stream_feeder dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_clear  (m_axis_clear),
      .m_axis_tready (m_axis_tready),
      .frame_err     (frame_err),
      .msg_count     (msg_count)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Cycle counter used to measure latency in whole clocks.
   always @(posedge clk) cyc <= cyc + 1;

   // The single comparison point: counts every check and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end else begin
         passCount++;
      end
   endtask

   // Downstream ready: always on, random, or the fixed 1,0,0,1 pattern.
   always @(negedge clk) begin
      if (readyMode == 1) begin
         m_axis_tready = ($urandom_range(0, 3) != 0);
      end else if (readyMode == 2) begin
         m_axis_tready = readyPattern[patIdx % 4];
         patIdx++;
      end else begin
         m_axis_tready = 1'b1;
      end
   end

   // Output monitor, sampling just before each rising edge: records handshakes,
   // counts error pulses and checks that a stalled output does not move.
   always begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
         holdPending = 0;
      end else begin
         if (frame_err) errSeen++;
         if (holdPending) begin
            checkOutput("hold_stable", {29'd0, m_axis_tvalid, m_axis_clear, m_axis_tlast, m_axis_tdata},
                        {29'd0, heldVal});
         end
         if (m_axis_tvalid && m_axis_tready) begin
            obsQ.push_back({m_axis_clear, m_axis_tlast, m_axis_tdata});
            if (firstOutCyc < 0) firstOutCyc = cyc;
         end
         holdPending = m_axis_tvalid && !m_axis_tready;
         heldVal     = {m_axis_tvalid, m_axis_clear, m_axis_tlast, m_axis_tdata};
      end
   end

   // Beat assembly helpers for the directed and random stimulus.
   task automatic setLane(input int i, input logic [31:0] w, input logic [3:0] k);
      curData[i*32 +: 32] = w;
      curKeep[i*4 +: 4]   = k;
   endtask

   task automatic commitBeat();
      beatDataQ.push_back(curData);
      beatKeepQ.push_back(curKeep);
      curData = '0;
      curKeep = '0;
   endtask

   // Reference model: flatten the queued beats into a word stream, then read it
   // as back-to-back (count, words...) records.
   function automatic void buildModel();
      logic [31:0] words[$];
      int          idx;
      for (int b = 0; b < beatDataQ.size(); b++) begin
         for (int i = 0; i < 16; i++) begin
            if (beatKeepQ[b][i*4 +: 4] == 4'hF) begin
               words.push_back(beatDataQ[b][i*32 +: 32]);
            end else if (beatKeepQ[b][i*4 +: 4] != 4'h0) begin
               expErr++;
            end
         end
      end
      idx = 0;
      while (idx < words.size()) begin
         longint n;
         n = words[idx];
         idx++;
         if (n == 0) begin
            expErr++;
         end else begin
            for (longint j = 0; j < n && idx < words.size(); j++) begin
               expQ.push_back({(j == 0), (j == n - 1), words[idx]});
               if (j == n - 1) expMsgsTotal++;
               idx++;
            end
         end
      end
   endfunction

   // Present one beat starting at a falling edge and hold it until accepted.
   task automatic applyStimulus(input logic [511:0] d, input logic [63:0] k);
      bit done = 0;
      int waitCyc = 0;
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = 1'($urandom_range(0, 1));
      while (!done && waitCyc < 300) begin
         #4;
         if (s_axis_tready) begin
            done      = 1;
            acceptCyc = cyc;
         end else begin
            sawTreadyLow = 1;
         end
         @(negedge clk);
         waitCyc++;
      end
      if (!done) checkOutput("beat_accept_timeout", 64'd0, 64'd1);
   endtask

   // Run one phase: model the queued beats, send them, drain, compare everything.
   task automatic runPhase(input int mode, input string name);
      expQ.delete();
      obsQ.delete();
      expErr       = 0;
      errSeen      = 0;
      sawTreadyLow = 0;
      firstOutCyc  = -1;
      patIdx       = 0;
      buildModel();
      @(negedge clk);
      readyMode = mode;
      for (int b = 0; b < beatDataQ.size(); b++) begin
         applyStimulus(beatDataQ[b], beatKeepQ[b]);
      end
      s_axis_tvalid = 1'b0;
      s_axis_tkeep  = '0;
      readyMode     = 0;
      repeat (80) @(negedge clk);
      checkOutput({name, "_out_count"}, obsQ.size(), expQ.size());
      for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
         checkOutput({name, "_out_word"}, obsQ[i], expQ[i]);
      end
      checkOutput({name, "_frame_err_count"}, errSeen, expErr);
      checkOutput({name, "_msg_count"}, msg_count, expMsgsTotal);
      beatDataQ.delete();
      beatKeepQ.delete();
   endtask

   // Everything observable must sit at zero while reset is held.
   task automatic checkResetState();
      checkOutput("rst_s_tready", s_axis_tready, 0);
      checkOutput("rst_m_tvalid", m_axis_tvalid, 0);
      checkOutput("rst_m_tlast", m_axis_tlast, 0);
      checkOutput("rst_m_clear", m_axis_clear, 0);
      checkOutput("rst_m_tdata", m_axis_tdata, 0);
      checkOutput("rst_frame_err", frame_err, 0);
      checkOutput("rst_msg_count", msg_count, 0);
   endtask

   // Random datasets (occasionally zero-length) packed into beats with padding,
   // malformed lanes and all-padding beats sprinkled in.
   task automatic genRandom();
      logic [31:0] words[$];
      int nsets = $urandom_range(3, 7);
      int idx = 0;
      for (int s = 0; s < nsets; s++) begin
         int n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 24);
         words.push_back(n);
         for (int j = 0; j < n; j++) words.push_back($urandom());
      end
      while (idx < words.size()) begin
         if ($urandom_range(0, 9) == 0) begin
            commitBeat();
         end else begin
            for (int i = 0; i < 16; i++) begin
               int r = $urandom_range(0, 19);
               if (r == 1) begin
                  setLane(i, $urandom(), 4'($urandom_range(1, 14)));
               end else if (r != 0 && idx < words.size()) begin
                  setLane(i, words[idx], 4'hF);
                  idx++;
               end
            end
            commitBeat();
         end
      end
   endtask

   // Main sequence: reset, directed datasets, mid-dataset reset, random streams.
   initial begin
      int w;
      rst_n         = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      m_axis_tready = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      #4 checkResetState();
      @(negedge clk);
      rst_n = 1'b1;
      #4 checkOutput("tready_after_reset", s_axis_tready, 1);

      // Three-integer dataset with padding; header in lane 0 sets the latency.
      setLane(0, 3, 4'hF); setLane(1, 10, 4'hF); setLane(2, 20, 4'hF); setLane(3, 30, 4'hF);
      commitBeat();
      runPhase(0, "A");
      checkOutput("A_latency", firstOutCyc - acceptCyc, 3);

      // Dataset of 20 spanning three beats, then a second dataset in the last beat.
      setLane(15, 20, 4'hF);
      commitBeat();
      for (int i = 0; i < 16; i++) setLane(i, i + 1, 4'hF);
      commitBeat();
      for (int i = 0; i < 4; i++) setLane(i, 17 + i, 4'hF);
      setLane(4, 2, 4'hF); setLane(5, 7, 4'hF); setLane(6, 8, 4'hF);
      commitBeat();
      runPhase(1, "B");

      // Back-pressure with ready 1,0,0,1 and a second beat queued behind.
      setLane(0, 4, 4'hF); setLane(1, 5, 4'hF); setLane(2, 6, 4'hF); setLane(3, 7, 4'hF); setLane(4, 8, 4'hF);
      commitBeat();
      setLane(0, 1, 4'hF); setLane(1, 99, 4'hF);
      commitBeat();
      runPhase(2, "C");
      checkOutput("C_tready_backpressure", sawTreadyLow, 1);

      // Zero-length header followed by a single-integer dataset.
      setLane(0, 0, 4'hF); setLane(1, 1, 4'hF); setLane(2, 42, 4'hF);
      commitBeat();
      runPhase(0, "D");

      // Malformed lane in the middle of a dataset, then an all-padding beat.
      setLane(0, 4, 4'hF); setLane(1, 1, 4'hF); setLane(2, 2, 4'hF);
      setLane(3, 32'h55, 4'b0011); setLane(4, 3, 4'hF); setLane(5, 4, 4'hF);
      commitBeat();
      commitBeat();
      runPhase(1, "E");

      // Reset in the middle of a five-integer dataset.
      @(negedge clk);
      obsQ.delete();
      readyMode = 0;
      for (int i = 0; i < 6; i++) setLane(i, (i == 0) ? 5 : i, 4'hF);
      applyStimulus(curData, curKeep);
      s_axis_tvalid = 1'b0;
      curData = '0;
      curKeep = '0;
      w = 0;
      while (obsQ.size() < 2 && w < 50) begin
         @(posedge clk);
         w++;
      end
      checkOutput("F_outputs_before_reset", (obsQ.size() >= 2), 1);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      #4 checkResetState();
      @(negedge clk);
      rst_n = 1'b1;
      #4 checkOutput("F_tready_after_reset", s_axis_tready, 1);
      expMsgsTotal = 0;
      setLane(0, 2, 4'hF); setLane(1, 9, 4'hF); setLane(2, 9, 4'hF);
      commitBeat();
      runPhase(0, "F");

      // Randomized streams under random downstream back-pressure.
      for (int p = 0; p < 8; p++) begin
         genRandom();
         runPhase((p % 3 == 0) ? 0 : 1, "R");
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
